wb_initiator: RTL
=================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter ADR_W, 32, Wishbone byte-address width.
REQ-002 Parameter TIMEOUT, 255, max cycles per attempt from strobe issue to termination (1..65535).
REQ-003 Parameter MAX_RETRY, 3, max reissues after wb_rty_i (0..15).
REQ-004 Port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 Port rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port cmd_valid_i  in  1  command present.
REQ-007 Port cmd_ready_o  out  1  command accepted when valid&ready.
REQ-008 Port cmd_we_i  in  1  1=write, 0=read.
REQ-009 Port cmd_adr_i  in  ADR_W  byte address.
REQ-010 Port cmd_sel_i  in  4  byte selects.
REQ-011 Port cmd_dat_i  in  32  write data.
REQ-012 Port rsp_valid_o  out  1  one-cycle response pulse, no backpressure.
REQ-013 Port rsp_dat_o  out  32  read data (0 for writes/failures).
REQ-014 Port rsp_status_o  out  2  00 ok, 01 err, 10 timeout, 11 retries exhausted.
REQ-015 Ports wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_adr_o  out  ADR_W; wb_sel_o  out  4; wb_dat_o  out  32: pipelined Wishbone B4 master outputs.
REQ-016 Ports wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each; wb_dat_i  in  32: slave returns.

Function
REQ-017 All outputs SHALL be registered; single outstanding transaction.
REQ-018 FSM states SHALL be IDLE, STROBE, WAIT, GAP.
REQ-019 IDLE: cmd_ready_o=1; on cmd_valid_i, capture we/adr/sel/dat, clear retry and timeout counters, go STROBE; cyc=stb=1 the next cycle.
REQ-020 STROBE: stb, adr, sel, we, dat held stable while wb_stall_i=1; first cycle with wb_stall_i=0 is the accept cycle; next cycle stb=0, cyc=1, state WAIT.
REQ-021 Terminations SHALL be sampled in the accept cycle and in every WAIT cycle; ignored otherwise.
REQ-022 Simultaneous terminations: priority err > rty > ack.
REQ-023 ack: next cycle cyc=0, rsp_valid_o=1, status 00, rsp_dat_o=wb_dat_i for reads, 0 for writes; state IDLE.
REQ-024 err: as REQ-023 with status 01, rsp_dat_o=0.
REQ-025 rty with retry count < MAX_RETRY: increment count, next cycle cyc=stb=0 (GAP, exactly one cycle), then reissue same captured command in STROBE with timeout counter cleared.
REQ-026 rty with retry count = MAX_RETRY: respond status 11, rsp_dat_o=0, IDLE.
REQ-027 Timeout counter SHALL count every cycle in STROBE and WAIT (stall cycles included); when it reaches TIMEOUT with no termination, next cycle cyc=stb=0, rsp_valid_o=1, status 10, IDLE.
REQ-028 Termination in the same cycle the counter reaches TIMEOUT SHALL win over timeout.
REQ-029 Command latency: accept at cycle N -> stb at N+1; zero-stall, ack at N+2 -> rsp_valid_o at N+3 with cmd_ready_o=1, so a new command may be accepted in that cycle.
REQ-030 cmd inputs SHALL be ignored outside IDLE; wb inputs ignored in IDLE and GAP.

Reset
REQ-031 rst_i=1 at any clock edge SHALL force IDLE, counters 0, cyc/stb/we=0, adr/sel/dat=0, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, cmd_ready_o=0 during reset, 1 the first cycle after release.
REQ-032 Reset mid-transaction SHALL drop cyc/stb at that edge with no response pulse.

Verification
REQ-033 Read adr 0x4, no stall, ack next cycle with wb_dat_i=0xDEADBEEF -> rsp_valid_o at N+3, rsp_dat_o=0xDEADBEEF, status 00.
REQ-034 Write adr 0x0 dat 0x12345678 sel 0xF, stall 3 cycles -> stb 4 cycles with stable adr/dat, ack -> status 00, rsp_dat_o=0.
REQ-035 Slave asserts rty on every attempt, MAX_RETRY=3 -> 4 strobes each separated by one cyc=0 cycle, then status 11.
REQ-036 Slave never terminates, TIMEOUT=16 -> cyc drops after 16 cycles, status 10; ack on cycle 16 instead -> status 00.
REQ-037 ack and err asserted together -> status 01; rst_i pulsed in WAIT -> cyc=0 next cycle, no rsp_valid_o, next command completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined single-outstanding initiator.
// Accepts one command at a time, issues it on the bus, and returns a one-cycle
// response pulse carrying read data and a completion status. Handles stall,
// err/rty/ack terminations, bounded retries and a per-attempt timeout.
module wb_initiator #(
  parameter int unsigned ADR_W     = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,

  // Command side
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      cmd_dat_i,

  // Response side
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_dat_o,
  output logic [1:0]       rsp_status_o,

  // Wishbone master
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  input  logic             wb_stall_i,
  input  logic [31:0]      wb_dat_i
);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusErr     = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;
  localparam logic [1:0] StatusRetry   = 2'b11;

  localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RetryLast = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWait,
    StGap
  } state_e;

  state_e      state_q;
  logic [3:0]  retry_q;
  logic [15:0] tmo_q;

  // Decoded termination for the current cycle
  logic        busy;
  logic        sample;
  logic        fin;
  logic        reissue;
  logic [1:0]  fin_status;
  logic [31:0] fin_dat;

  // Resolve terminations (err > rty > ack > timeout) for this cycle
  always_comb begin
    busy       = (state_q == StStrobe) || (state_q == StWait);
    // Terminations only count in the strobe accept cycle or while waiting
    sample     = ((state_q == StStrobe) && !wb_stall_i) || (state_q == StWait);
    fin        = 1'b0;
    reissue    = 1'b0;
    fin_status = StatusOk;
    fin_dat    = 32'h0;
    if (busy) begin
      if (sample && wb_err_i) begin
        fin        = 1'b1;
        fin_status = StatusErr;
      end else if (sample && wb_rty_i) begin
        if (retry_q != RetryLast) begin
          reissue = 1'b1;
        end else begin
          fin        = 1'b1;
          fin_status = StatusRetry;
        end
      end else if (sample && wb_ack_i) begin
        fin        = 1'b1;
        fin_status = StatusOk;
        fin_dat    = wb_we_o ? 32'h0 : wb_dat_i;
      end else if (tmo_q == TmoLast) begin
        fin        = 1'b1;
        fin_status = StatusTimeout;
      end
    end
  end

  // Main FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      retry_q      <= 4'h0;
      tmo_q        <= 16'h0;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= 32'h0;
      rsp_status_o <= StatusOk;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= 4'h0;
      wb_dat_o     <= 32'h0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            wb_we_o     <= cmd_we_i;
            wb_adr_o    <= cmd_adr_i;
            wb_sel_o    <= cmd_sel_i;
            wb_dat_o    <= cmd_dat_i;
            retry_q     <= 4'h0;
            tmo_q       <= 16'h0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            cmd_ready_o <= 1'b0;
            state_q     <= StStrobe;
          end
        end

        StStrobe, StWait: begin
          tmo_q <= tmo_q + 16'h1;
          if (fin) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= fin_status;
            rsp_dat_o    <= fin_dat;
            cmd_ready_o  <= 1'b1;
            state_q      <= StIdle;
          end else if (reissue) begin
            retry_q  <= retry_q + 4'h1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_q  <= StGap;
          end else if ((state_q == StStrobe) && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state_q  <= StWait;
          end
        end

        StGap: begin
          // One idle bus cycle, then reissue the captured command
          tmo_q    <= 16'h0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state_q  <= StStrobe;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
